// File: rtl/bounce_generator_if.sv
// Request/status bundle between a bounce_generator and whatever drives it.
// The master drives requests; the slave (the generator) returns line and status.
interface bounce_generator_if #(
    parameter int unsigned CNT_W = 4
);
    logic             i_w_start;
    logic             i_w_level;
    logic [CNT_W-1:0] i_w_bounces;
    logic             o_w_out;
    logic             o_w_busy;
    logic             o_w_done;

    modport master (
        output i_w_start, i_w_level, i_w_bounces,
        input  o_w_out, o_w_busy, o_w_done
    );

    modport slave (
        input  i_w_start, i_w_level, i_w_bounces,
        output o_w_out, o_w_busy, o_w_done
    );
endinterface

// File: rtl/bounce_generator.sv
// Drives a deliberately bouncy line to a target level, then holds it and pulses done.
// Define BOUNCE_LFSR_EN for pseudo-random gaps; otherwise every gap is 2^(GAP_W-1) cycles.
module bounce_generator #(
    parameter int unsigned CNT_W         = 4,
    parameter int unsigned GAP_W         = 3,
    parameter int unsigned SETTLE_CYCLES = 16
`ifdef BOUNCE_LFSR_EN
    , parameter logic [7:0] LFSR_SEED    = 8'hA5
`endif
) (
    input logic              i_w_clk,
    input logic              i_w_reset,
    bounce_generator_if.slave bus
);

    localparam int unsigned GW = GAP_W + 1;
    localparam int unsigned RW = CNT_W + 1;
    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BOUNCE,
        S_SETTLE,
        S_ACK
    } state_t;

    state_t        state_q, state_d;
    logic          out_q, out_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [RW-1:0] rem_q, rem_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [GW-1:0] gap_load;

`ifdef BOUNCE_LFSR_EN
    localparam logic [7:0] SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

    logic [7:0] lfsr_q;
    logic       lfsr_fb;

    // x^8+x^6+x^5+x^4+1 Fibonacci form, free-running out of reset
    assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

    always_ff @(posedge i_w_clk or negedge i_w_reset) begin
        if (!i_w_reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_fb};
        end
    end

    assign gap_load = GW'(lfsr_q[GAP_W-1:0]) + GW'(1);
`else
    assign gap_load = GW'(2 ** (GAP_W - 1));
`endif

    // State and registered outputs
    always_ff @(posedge i_w_clk or negedge i_w_reset) begin
        if (!i_w_reset) begin
            state_q  <= S_IDLE;
            out_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rem_q    <= '0;
            gap_q    <= '0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rem_q    <= rem_d;
            gap_q    <= gap_d;
            settle_q <= settle_d;
        end
    end

    // Next-state logic; an odd toggle count (2*bounces+1) always lands on the target level
    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        rem_d    = rem_q;
        gap_d    = gap_q;
        settle_d = settle_q;

        case (state_q)
            S_IDLE: begin
                // A start seen while done is still high is the tail of the last job
                if (bus.i_w_start && !done_q) begin
                    busy_d = 1'b1;
                    if (bus.i_w_level != out_q) begin
                        out_d = ~out_q;
                        rem_d = {bus.i_w_bounces, 1'b0};
                        gap_d = gap_load;
                        if (bus.i_w_bounces == '0) begin
                            settle_d = SETTLE_LOAD;
                            state_d  = S_SETTLE;
                        end else begin
                            state_d = S_BOUNCE;
                        end
                    end else begin
                        state_d = S_ACK;
                    end
                end
            end

            S_BOUNCE: begin
                if (gap_q == GW'(1)) begin
                    out_d = ~out_q;
                    rem_d = rem_q - RW'(1);
                    if (rem_q == RW'(1)) begin
                        settle_d = SETTLE_LOAD;
                        state_d  = S_SETTLE;
                    end else begin
                        gap_d = gap_load;
                    end
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end

            S_SETTLE: begin
                if (settle_q == '0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    settle_d = settle_q - SW'(1);
                end
            end

            S_ACK: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.o_w_out  = out_q;
    assign bus.o_w_busy = busy_q;
    assign bus.o_w_done = done_q;

endmodule

// File: tb/tb_bounce_generator.sv
// Directed bench for bounce_generator: cycle traces compared against hand-derived patterns.
module tb_bounce_generator;

    localparam int unsigned TW = 320;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    bounce_generator_if #(.CNT_W(4)) bus ();

    bounce_generator dut (
        .i_w_clk   (clk),
        .i_w_reset (rst_n),
        .bus       (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [TW-1:0] tr_out, tr_busy, tr_done;
    logic [TW-1:0] e_out, e_busy, e_done;
    logic [TW-1:0] ref_out, ref_done;

    task automatic check(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int first_one(input logic [TW-1:0] v);
        for (int i = 0; i < int'(TW); i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        bus.i_w_start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Issue one start; trace index k is the value just after edge t+k
    task automatic run_seq(input logic lvl, input logic [3:0] b, input int n,
                           input bit alter, input int alt_last);
        tr_out  = '0;
        tr_busy = '0;
        tr_done = '0;
        @(negedge clk);
        bus.i_w_start   = 1'b1;
        bus.i_w_level   = lvl;
        bus.i_w_bounces = b;
        @(posedge clk);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            tr_out[k]  = bus.o_w_out;
            tr_busy[k] = bus.o_w_busy;
            tr_done[k] = bus.o_w_done;
            if (alter && k <= alt_last) begin
                bus.i_w_start   = 1'b1;
                bus.i_w_level   = ~lvl;
                bus.i_w_bounces = 4'(k);
            end else begin
                bus.i_w_start = 1'b0;
            end
        end
    endtask

    // Fixed-gap expectation: toggles every 4 edges, done 16 edges after the last toggle
    task automatic build_exp(input logic prev, input logic lvl, input int b, input int n);
        int ntog;
        int d;
        e_out  = '0;
        e_busy = '0;
        e_done = '0;
        d = 8 * b + 16;
        for (int k = 0; k < n; k++) begin
            if (lvl == prev) begin
                e_out[k]  = prev;
                e_busy[k] = (k == 0);
                e_done[k] = (k == 1);
            end else begin
                ntog      = (k <= 8 * b) ? (k / 4 + 1) : (2 * b + 1);
                e_out[k]  = prev ^ ntog[0];
                e_busy[k] = (k < d);
                e_done[k] = (k == d);
            end
        end
    endtask

    initial begin
        logic [20:0] s3_head;
        int ntog;
        int last;
        int bad;
        logic prev;

        rst_n = 1'b0;
        bus.i_w_start   = 1'b0;
        bus.i_w_level   = 1'b0;
        bus.i_w_bounces = 4'd0;
        #12;
        check("rst_out",  bus.o_w_out,  0);
        check("rst_busy", bus.o_w_busy, 0);
        check("rst_done", bus.o_w_done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Asynchronous reset in the middle of a bounce burst
        run_seq(1'b1, 4'd2, 1, 1'b0, 0);
        check("s1_pre_out",  bus.o_w_out,  1);
        check("s1_pre_busy", bus.o_w_busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("s1_rst_out",  bus.o_w_out,  0);
        check("s1_rst_busy", bus.o_w_busy, 0);
        check("s1_rst_done", bus.o_w_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Zero bounces: single toggle, then settle
        run_seq(1'b1, 4'd0, 24, 1'b0, 0);
        build_exp(1'b0, 1'b1, 0, 24);
        check("s2_out",    tr_out,  e_out);
        check("s2_busy",   tr_busy, e_busy);
        check("s2_done",   tr_done, e_done);
        check("s2_done_k", first_one(tr_done), 16);

        // Target already present: acknowledge only
        do_reset();
        run_seq(1'b0, 4'd5, 8, 1'b0, 0);
        build_exp(1'b0, 1'b0, 5, 8);
        check("s4_out",  tr_out,  e_out);
        check("s4_busy", tr_busy, e_busy);
        check("s4_done", tr_done, e_done);

        // Same acknowledge path with the line already high
        run_seq(1'b1, 4'd0, 20, 1'b0, 0);
        run_seq(1'b1, 4'd3, 8, 1'b0, 0);
        build_exp(1'b1, 1'b1, 3, 8);
        check("s4h_out",  tr_out,  e_out);
        check("s4h_busy", tr_busy, e_busy);
        check("s4h_done", tr_done, e_done);

`ifndef BOUNCE_LFSR_EN
        // Two glitch pairs with fixed gap of 4
        do_reset();
        run_seq(1'b1, 4'd2, 40, 1'b0, 0);
        build_exp(1'b0, 1'b1, 2, 40);
        check("s3_out",  tr_out,  e_out);
        check("s3_busy", tr_busy, e_busy);
        check("s3_done", tr_done, e_done);
        s3_head = tr_out[20:0];
        check("s3_out_head", s3_head, 21'b11111_0000_1111_0000_1111);
        check("s3_done_k", first_one(tr_done), 32);

        // Inputs churned while busy and during the done cycle must change nothing
        do_reset();
        run_seq(1'b1, 4'd2, 40, 1'b1, 32);
        build_exp(1'b0, 1'b1, 2, 40);
        check("s5_out",  tr_out,  e_out);
        check("s5_busy", tr_busy, e_busy);
        check("s5_done", tr_done, e_done);

        // Maximum bounce count
        do_reset();
        run_seq(1'b1, 4'd15, 150, 1'b0, 0);
        build_exp(1'b0, 1'b1, 15, 150);
        check("bmax_out",  tr_out,  e_out);
        check("bmax_busy", tr_busy, e_busy);
        check("bmax_done", tr_done, e_done);
`else
        // Random gaps: structure checks, then a second run must repeat exactly
        do_reset();
        run_seq(1'b1, 4'd15, 300, 1'b0, 0);
        prev = 1'b0;
        ntog = 0;
        last = -1;
        bad  = 0;
        for (int k = 0; k < 300; k++) begin
            if (tr_out[k] != prev) begin
                ntog++;
                if (last >= 0 && ((k - last) < 1 || (k - last) > 8)) bad++;
                last = k;
                prev = tr_out[k];
            end
        end
        check("s6_toggles",   ntog, 31);
        check("s6_gap_range", bad,  0);
        check("s6_final",     tr_out[299], 1);
        check("s6_done_k",    first_one(tr_done), last + 16);
        check("s6_done_cnt",  $countones(tr_done), 1);
        ref_out  = tr_out;
        ref_done = tr_done;
        do_reset();
        run_seq(1'b1, 4'd15, 300, 1'b0, 0);
        check("s6_repeat_out",  tr_out,  ref_out);
        check("s6_repeat_done", tr_done, ref_done);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
